// File: rtl/hdmi_pkg.sv
// Package: hdmi_pkg
// Shared timing constants and data types for the HDMI scan-out path.
//   H_* / V_*  : 640x480@60 Hz raster timing (pixel clocks / lines)
//   RAM_LAT    : read latency of the external row and colour RAMs
//   rgb_t      : packed {R,G,B} 8 bits each
//   color_idx_t: colour RAM index held in the row RAM
package hdmi_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int RAM_LAT  = 1;

    typedef logic [23:0] rgb_t;
    typedef logic [9:0]  color_idx_t;

    // True on the lines whose end releases the current row buffer: the
    // second scan of each native row, plus the last line of the frame so
    // the renderer can prime row 0 before the next frame starts.
    function automatic logic swap_line(input logic [9:0] vcount,
                                       input logic [9:0] v_active,
                                       input logic [9:0] v_last);
        logic res_s;
        if (vcount == v_last) begin
            res_s = 1'b1;
        end else if (vcount[0] && (vcount < v_active)) begin
            res_s = 1'b1;
        end else begin
            res_s = 1'b0;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/hdmi_video_out_timing.sv
// Module: vga_timing_gen
// Free-running raster counters and raw (undelayed) sync/enable decode.
//   video_clk in  pixel clock
//   rst_n     in  asynchronous active-low reset
//   hcount    out horizontal position 0..H_TOTAL-1
//   vcount    out line number 0..V_TOTAL-1
//   de_raw    out active-region flag at counter stage
//   hs_raw    out horizontal sync (active low) at counter stage
//   vs_raw    out vertical sync (active low) at counter stage
module vga_timing_gen
    import hdmi_pkg::*;
#(
    parameter int V_ACTIVE_P = V_ACTIVE,
    parameter int V_FP_P     = V_FP,
    parameter int V_SYNC_P   = V_SYNC,
    parameter int V_BP_P     = V_BP
) (
    input  logic       video_clk,
    input  logic       rst_n,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       de_raw,
    output logic       hs_raw,
    output logic       vs_raw
);

    localparam logic [9:0] H_ACT_L   = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST_L  = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_BEG_L  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END_L  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT_L   = 10'(V_ACTIVE_P);
    localparam logic [9:0] V_LAST_L  = 10'(V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P - 1);
    localparam logic [9:0] VS_BEG_L  = 10'(V_ACTIVE_P + V_FP_P);
    localparam logic [9:0] VS_END_L  = 10'(V_ACTIVE_P + V_FP_P + V_SYNC_P);

    logic [9:0] hcount_r;
    logic [9:0] vcount_r;

    // Raster position counters: hcount wraps each line and advances vcount.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_r <= 10'd0;
            vcount_r <= 10'd0;
        end else if (hcount_r == H_LAST_L) begin
            hcount_r <= 10'd0;
            if (vcount_r == V_LAST_L) begin
                vcount_r <= 10'd0;
            end else begin
                vcount_r <= vcount_r + 10'd1;
            end
        end else begin
            hcount_r <= hcount_r + 10'd1;
        end
    end

    // Raw timing decode straight from the counter registers.
    always_comb begin
        de_raw = (hcount_r < H_ACT_L) && (vcount_r < V_ACT_L);
        hs_raw = !((hcount_r >= HS_BEG_L) && (hcount_r < HS_END_L));
        vs_raw = !((vcount_r >= VS_BEG_L) && (vcount_r < VS_END_L));
    end

    assign hcount = hcount_r;
    assign vcount = vcount_r;

endmodule

// File: rtl/hdmi_video_out.sv
// Module: hdmi_video_out
// Scan-out stage: 640x480@60 timing, 2x pixel/line doubling of a 320x240
// frame held in an external double-buffered row RAM, palette lookup in an
// external colour RAM, and row-buffer swap signalling.
//   video_clk     in  25 MHz pixel clock
//   rst_n         in  asynchronous active-low reset
//   vga_pclk      out ~video_clk, so data is launched mid-period
//   vga_de/hs/vs  out enable and active-low syncs, aligned with vga_rgb
//   vga_rgb       out {R,G,B}, forced to zero outside the active region
//   rowram_rdaddr out native x (hcount/2) during active pixels, else 0
//   rowram_rddata in  colour index, one clock after the address
//   color_rdaddr  out colour RAM index (= rowram_rddata)
//   color_rddata  in  RGB entry, one clock after the index
//   rowram_swap   out one-clock pulse at hcount==640 when a row buffer is done
module hdmi_video_out
    import hdmi_pkg::*;
#(
    parameter int V_ACTIVE_P = V_ACTIVE,
    parameter int V_FP_P     = V_FP,
    parameter int V_SYNC_P   = V_SYNC,
    parameter int V_BP_P     = V_BP
) (
    input  logic        video_clk,
    input  logic        rst_n,
    output logic        vga_pclk,
    output logic        vga_de,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [23:0] vga_rgb,
    output logic [8:0]  rowram_rdaddr,
    input  logic [9:0]  rowram_rddata,
    output logic [9:0]  color_rdaddr,
    input  logic [23:0] color_rddata,
    output logic        rowram_swap
);

    localparam logic [9:0] H_ACT_L  = 10'(H_ACTIVE);
    localparam logic [9:0] H_PRE_L  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_ACT_L  = 10'(V_ACTIVE_P);
    localparam logic [9:0] V_LAST_L = 10'(V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P - 1);

    logic [9:0] hcount_s;
    logic [9:0] vcount_s;
    logic       de_raw_s;
    logic       hs_raw_s;
    logic       vs_raw_s;

    logic       de_d1_r, hs_d1_r, vs_d1_r;
    logic       de_d2_r, hs_d2_r, vs_d2_r;
    logic       swap_r;

    vga_timing_gen #(
        .V_ACTIVE_P (V_ACTIVE_P),
        .V_FP_P     (V_FP_P),
        .V_SYNC_P   (V_SYNC_P),
        .V_BP_P     (V_BP_P)
    ) u_timing (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .hcount    (hcount_s),
        .vcount    (vcount_s),
        .de_raw    (de_raw_s),
        .hs_raw    (hs_raw_s),
        .vs_raw    (vs_raw_s)
    );

    assign vga_pclk = ~video_clk;

    // Row RAM address: both pixels of a doubled pair read the same native x.
    always_comb begin
        if (hcount_s < H_ACT_L) begin
            rowram_rdaddr = hcount_s[9:1];
        end else begin
            rowram_rdaddr = 9'd0;
        end
    end

    assign color_rdaddr = rowram_rddata;

    // Two-stage sync/enable delay matching row RAM + colour RAM read latency.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d1_r <= 1'b0;
            hs_d1_r <= 1'b1;
            vs_d1_r <= 1'b1;
            de_d2_r <= 1'b0;
            hs_d2_r <= 1'b1;
            vs_d2_r <= 1'b1;
        end else begin
            de_d1_r <= de_raw_s;
            hs_d1_r <= hs_raw_s;
            vs_d1_r <= vs_raw_s;
            de_d2_r <= de_d1_r;
            hs_d2_r <= hs_d1_r;
            vs_d2_r <= vs_d1_r;
        end
    end

    // Swap pulse is decoded one clock early (hcount==639) so the registered
    // pulse coincides exactly with hcount==640 on the same line.
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_r <= 1'b0;
        end else begin
            swap_r <= (hcount_s == H_PRE_L) && swap_line(vcount_s, V_ACT_L, V_LAST_L);
        end
    end

    // The colour RAM output register is the final pipeline stage; blank it
    // with the aligned enable so porch/sync data never reaches the link.
    always_comb begin
        if (de_d2_r) begin
            vga_rgb = color_rddata;
        end else begin
            vga_rgb = 24'h000000;
        end
    end

    assign vga_de      = de_d2_r;
    assign vga_hs      = hs_d2_r;
    assign vga_vs      = vs_d2_r;
    assign rowram_swap = swap_r;

endmodule

// File: tb/tb_hdmi_video_out.sv
// Directed bench for hdmi_video_out with row RAM and palette RAM models.
// Vertical timing is shortened through the top-level parameters so that
// several complete frames fit in a short run; horizontal timing is full.
module tb_hdmi_video_out;

    localparam int HT    = 800;
    localparam int VA    = 6;
    localparam int VFP   = 2;
    localparam int VSY   = 2;
    localparam int VBP   = 2;
    localparam int VT    = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;

    logic        video_clk = 1'b0;
    logic        rst_n     = 1'b0;
    logic        vga_pclk, vga_de, vga_hs, vga_vs, rowram_swap;
    logic [23:0] vga_rgb;
    logic [8:0]  rowram_rdaddr;
    logic [9:0]  rowram_rddata;
    logic [9:0]  color_rdaddr;
    logic [23:0] color_rddata;

    logic [9:0]  row_mem [0:511];
    logic [23:0] pal_mem [0:1023];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   k       = 0;
    logic white   = 1'b0;
    int   de_cnt = 0, hs_lo_cnt = 0, vs_lo_cnt = 0, swap_cnt = 0;
    int   first_swap_k = -1, last_swap_k = -1;

    hdmi_video_out #(
        .V_ACTIVE_P (VA),
        .V_FP_P     (VFP),
        .V_SYNC_P   (VSY),
        .V_BP_P     (VBP)
    ) dut (
        .video_clk     (video_clk),
        .rst_n         (rst_n),
        .vga_pclk      (vga_pclk),
        .vga_de        (vga_de),
        .vga_hs        (vga_hs),
        .vga_vs        (vga_vs),
        .vga_rgb       (vga_rgb),
        .rowram_rdaddr (rowram_rdaddr),
        .rowram_rddata (rowram_rddata),
        .color_rdaddr  (color_rdaddr),
        .color_rddata  (color_rddata),
        .rowram_swap   (rowram_swap)
    );

    always #20 video_clk = ~video_clk;

    // Registered-read RAM models on the same clock edge as the DUT.
    always @(posedge video_clk) begin
        rowram_rddata <= row_mem[rowram_rdaddr];
        color_rddata  <= pal_mem[color_rdaddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, k);
        end
    endtask

    // Advance one clock and compare every output with the raster reference.
    // k counts clocks since reset release; the counter sits at position k,
    // the displayed outputs belong to position k-2.
    task automatic step();
        int p, hp, vp, q, hq, vq;
        logic e_de, e_hs, e_vs, e_swap;
        logic [23:0] e_rgb;
        logic [8:0]  n, e_addr;
        @(negedge video_clk);
        k++;
        p  = k % FRAME;
        hp = p % HT;
        vp = p / HT;
        e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = 24'h000000;
        if (k >= 2) begin
            q  = (k - 2) % FRAME;
            hq = q % HT;
            vq = q / HT;
            e_de = (hq < 640) && (vq < VA);
            e_hs = !((hq >= 656) && (hq < 752));
            e_vs = !((vq >= VA + VFP) && (vq < VA + VFP + VSY));
            n    = 9'(hq / 2);
            if (e_de) e_rgb = white ? 24'hFFFFFF : {n[7:0], 8'h00, 8'hFF};
        end
        e_swap = (hp == 640) && (((vp % 2 == 1) && (vp < VA)) || (vp == VT - 1));
        e_addr = (hp < 640) ? 9'(hp / 2) : 9'd0;
        chk("vga_de", 32'(vga_de), 32'(e_de));
        chk("vga_hs", 32'(vga_hs), 32'(e_hs));
        chk("vga_vs", 32'(vga_vs), 32'(e_vs));
        chk("vga_rgb", 32'(vga_rgb), 32'(e_rgb));
        chk("rowram_swap", 32'(rowram_swap), 32'(e_swap));
        chk("rowram_rdaddr", 32'(rowram_rdaddr), 32'(e_addr));
        chk("vga_pclk_low_phase", 32'(vga_pclk), 32'd1);
        if (k >= 2 && k <= FRAME + 1) begin
            if (vga_de)  de_cnt++;
            if (!vga_hs) hs_lo_cnt++;
            if (!vga_vs) vs_lo_cnt++;
        end
        if (k <= FRAME && rowram_swap) begin
            swap_cnt++;
            if (first_swap_k < 0) first_swap_k = k;
            last_swap_k = k;
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++)  row_mem[i] = 10'(i);
        for (int i = 0; i < 1024; i++) pal_mem[i] = {8'(i), 8'h00, 8'hFF};

        // Reset state
        repeat (3) @(negedge video_clk);
        chk("rst_de", 32'(vga_de), 32'd0);
        chk("rst_hs", 32'(vga_hs), 32'd1);
        chk("rst_vs", 32'(vga_vs), 32'd1);
        chk("rst_rgb", 32'(vga_rgb), 32'd0);
        chk("rst_swap", 32'(rowram_swap), 32'd0);
        chk("rst_rdaddr", 32'(rowram_rdaddr), 32'd0);
        @(posedge video_clk);
        #1;
        chk("vga_pclk_high_phase", 32'(vga_pclk), 32'd0);
        @(negedge video_clk);
        rst_n = 1'b1;
        k = 0;

        // First frame: pixel pattern plus per-frame timing totals
        while (k < FRAME + 1) step();
        chk("de_clocks_per_frame", 32'(de_cnt), 32'(640 * VA));
        chk("hs_low_clocks_per_frame", 32'(hs_lo_cnt), 32'(96 * VT));
        chk("vs_low_clocks_per_frame", 32'(vs_lo_cnt), 32'(VSY * HT));
        chk("swap_pulses_per_frame", 32'(swap_cnt), 32'(VA / 2 + 1));
        chk("first_swap_position", 32'(first_swap_k), 32'(HT + 640));
        chk("last_swap_position", 32'(last_swap_k), 32'((VT - 1) * HT + 640));

        // Switch palette to white inside vertical blanking, then keep checking
        while (k < FRAME + VA * HT + 1000) step();
        for (int i = 0; i < 1024; i++) pal_mem[i] = 24'hFFFFFF;
        white = 1'b1;
        while (k < 3 * FRAME + 2) step();

        // Mid-line asynchronous reset at line 3, hcount 300
        while ((k % FRAME) != 3 * HT + 300) step();
        chk("pre_reset_de", 32'(vga_de), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_de", 32'(vga_de), 32'd0);
        chk("midrst_hs", 32'(vga_hs), 32'd1);
        chk("midrst_vs", 32'(vga_vs), 32'd1);
        chk("midrst_rgb", 32'(vga_rgb), 32'd0);
        chk("midrst_swap", 32'(rowram_swap), 32'd0);
        chk("midrst_rdaddr", 32'(rowram_rdaddr), 32'd0);
        repeat (3) @(negedge video_clk);
        rst_n = 1'b1;
        k = 0;
        while (k < FRAME + 10) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
